sna_vc_output_buffer: RTL and testbench



---
 rtl/sna_pkg.sv | 21 ++
 rtl/sna_vc_fifo.sv | 61 ++++++
 rtl/sna_vc_output_buffer.sv | 122 ++++++++++++
 tb/tb_sna_vc_output_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sna_pkg.sv
// Shared flit-format definitions for the SNA response path.
// Field positions, flit type codes and widths used by the output buffer and its FIFOs.
package sna_pkg;

  localparam int FLIT_W  = 37;
  localparam int NUM_VC  = 8;
  localparam int VC_W    = 3;

  localparam int TYPE_HI = 36;
  localparam int TYPE_LO = 35;
  localparam int VC_HI   = 34;
  localparam int VC_LO   = 32;

  localparam logic [1:0] FLIT_INV  = 2'b00;
  localparam logic [1:0] FLIT_HDR  = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/sna_vc_fifo.sv
// Single virtual-channel flit FIFO with synchronous push/pop and an extra count bit
// so that full and empty are distinguishable. The head flit is readable combinationally.
module sna_vc_fifo
  import sna_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FLIT_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_next_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_next_o = count_d;
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/sna_vc_output_buffer.sv
// Per-VC output buffer between the SNA response packetizer and the router link:
// buffers flits per VC, reports allocatable/on-off flow control, round-robin drains to the link.
module sna_vc_output_buffer
  import sna_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OFF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] noc_data,
  input  logic              is_valid,
  output logic [NUM_VC-1:0] is_allocatable,
  output logic [NUM_VC-1:0] is_on_off,
  input  logic [NUM_VC-1:0] link_on_off,
  output logic [FLIT_W-1:0] link_data,
  output logic              link_valid,
  output logic              overflow_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [FLIT_W-1:0] head       [NUM_VC];
  logic [CNT_W-1:0]  count_next [NUM_VC];
  logic [NUM_VC-1:0] full, empty, eligible, push_vec, pop_vec, tail_pop;
  logic [NUM_VC-1:0] owned_q, owned_d, owned_eff;
  logic [NUM_VC-1:0] alloc_q, alloc_d, onoff_q, onoff_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d, winner, idx;
  logic [FLIT_W-1:0] link_data_q;
  logic              link_valid_q, err_q, proto_err, found;
  logic [1:0]        in_type;
  logic [VC_W-1:0]   in_vc;

  assign in_type  = noc_data[TYPE_HI:TYPE_LO];
  assign in_vc    = noc_data[VC_HI:VC_LO];
  assign eligible = ~empty & link_on_off;

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      sna_vc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FLIT_W)
      ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_vec[gi]),
        .push_data_i  (noc_data),
        .pop_i        (pop_vec[gi]),
        .head_o       (head[gi]),
        .count_next_o (count_next[gi]),
        .full_o       (full[gi]),
        .empty_o      (empty[gi])
      );

      assign tail_pop[gi] = pop_vec[gi] && (head[gi][TYPE_HI:TYPE_LO] == FLIT_TAIL);
      // Flow control is derived from next-state so it reflects the edge that changed it.
      assign alloc_d[gi]  = !owned_d[gi] && (count_next[gi] == '0);
      assign onoff_d[gi]  = (FIFO_DEPTH - int'(count_next[gi])) >= OFF_MARGIN;
    end
  endgenerate

  always_comb begin
    found   = 1'b0;
    winner  = rr_ptr_q;
    idx     = rr_ptr_q;
    pop_vec = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = rr_ptr_q + VC_W'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found) pop_vec[winner] = 1'b1;
    rr_ptr_d = found ? winner + VC_W'(1) : rr_ptr_q;
  end

  // A tail leaving this cycle releases the VC before the incoming flit is judged.
  always_comb begin
    owned_eff = owned_q & ~tail_pop;
    proto_err = 1'b0;
    push_vec  = '0;
    if (is_valid) begin
      case (in_type)
        FLIT_INV: proto_err = 1'b1;
        FLIT_HDR: proto_err = owned_eff[in_vc];
        default:  proto_err = !owned_eff[in_vc];
      endcase
      if (full[in_vc] && !pop_vec[in_vc]) proto_err = 1'b1;
      if (!proto_err) push_vec[in_vc] = 1'b1;
    end
    owned_d = owned_eff;
    if (push_vec[in_vc] && (in_type == FLIT_HDR)) owned_d[in_vc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owned_q      <= '0;
      rr_ptr_q     <= '0;
      alloc_q      <= '1;
      onoff_q      <= '1;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      owned_q      <= owned_d;
      rr_ptr_q     <= rr_ptr_d;
      alloc_q      <= alloc_d;
      onoff_q      <= onoff_d;
      link_valid_q <= found;
      if (found) link_data_q <= head[winner];
      err_q        <= err_q | proto_err;
    end
  end

  assign is_allocatable = alloc_q;
  assign is_on_off      = onoff_q;
  assign link_data      = link_data_q;
  assign link_valid     = link_valid_q;
  assign overflow_err   = err_q;

endmodule

// File: tb/tb_sna_vc_output_buffer.sv
// Self-checking bench for sna_vc_output_buffer: per-cycle vector table plus hand-written
// round-robin and mid-operation reset sequences; link flits are checked against a scoreboard queue.
module tb_sna_vc_output_buffer;
  import sna_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [36:0] noc_data;
  logic        is_valid;
  logic [7:0]  is_allocatable;
  logic [7:0]  is_on_off;
  logic [7:0]  link_on_off;
  logic [36:0] link_data;
  logic        link_valid;
  logic        overflow_err;

  int checks = 0;
  int fails  = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_exp;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [36:0] data;
    logic [7:0]  on;
    logic        push;
    logic [7:0]  alloc;
    logic [7:0]  onoff;
    logic        err;
    logic        lv;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  sna_vc_output_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .noc_data       (noc_data),
    .is_valid       (is_valid),
    .is_allocatable (is_allocatable),
    .is_on_off      (is_on_off),
    .link_on_off    (link_on_off),
    .link_data      (link_data),
    .link_valid     (link_valid),
    .overflow_err   (overflow_err)
  );

  function automatic logic [36:0] flit(input logic [1:0] t, input logic [2:0] vc, input logic [31:0] p);
    return {t, vc, p};
  endfunction

  function automatic void add(input logic r, input logic v, input logic [36:0] d, input logic [7:0] on,
                              input logic p, input logic [7:0] a, input logic [7:0] o,
                              input logic e, input logic l);
    vec_t x;
    x.rst = r; x.vld = v; x.data = d; x.on = on; x.push = p;
    x.alloc = a; x.onoff = o; x.err = e; x.lv = l;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at a falling edge, advance through one rising edge, return at the next falling edge.
  task automatic step(input logic r, input logic v, input logic [36:0] d, input logic [7:0] on, input logic p);
    rst = r; is_valid = v; noc_data = d; link_on_off = on;
    if (p) exp_q.push_back(d);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (link_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL link_unexpected: got %h expected no flit", link_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("link_data", 64'(link_data), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; is_valid = 1'b0; noc_data = '0; link_on_off = '0;
    repeat (2) @(negedge clk);

    // header then tail on VC2, all VCs on
    add(1, 0, '0, 8'hFF, 0, 8'hFF, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_HDR, 3'd2, 32'hA000_0001), 8'hFF, 1, 8'hFB, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_TAIL, 3'd2, 32'hA000_0002), 8'hFF, 1, 8'hFB, 8'hFF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hFF, 8'hFF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hFF, 8'hFF, 0, 0);
    // fill VC0 while it is off, overflow on the 5th, then drain exactly 4
    add(1, 0, '0, 8'hFE, 0, 8'hFF, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_HDR,  3'd0, 32'h0000_0010), 8'hFE, 1, 8'hFE, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd0, 32'h0000_0011), 8'hFE, 1, 8'hFE, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd0, 32'h0000_0012), 8'hFE, 1, 8'hFE, 8'hFE, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd0, 32'h0000_0013), 8'hFE, 1, 8'hFE, 8'hFE, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd0, 32'h0000_0014), 8'hFE, 0, 8'hFE, 8'hFE, 1, 0);
    add(0, 0, '0, 8'hFF, 0, 8'hFE, 8'hFE, 1, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hFE, 8'hFF, 1, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hFE, 8'hFF, 1, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hFE, 8'hFF, 1, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hFE, 8'hFF, 1, 0);
    // second header on owned VC3 is dropped
    add(1, 0, '0, 8'hFF, 0, 8'hFF, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_HDR, 3'd3, 32'h0000_0030), 8'hFF, 1, 8'hF7, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_HDR, 3'd3, 32'h0000_0031), 8'hFF, 0, 8'hF7, 8'hFF, 1, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hF7, 8'hFF, 1, 0);
    // full VC4 accepts a push while popping; count stays at 4
    add(1, 0, '0, 8'hEF, 0, 8'hFF, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_HDR,  3'd4, 32'h0000_0040), 8'hEF, 1, 8'hEF, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd4, 32'h0000_0041), 8'hEF, 1, 8'hEF, 8'hFF, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd4, 32'h0000_0042), 8'hEF, 1, 8'hEF, 8'hEF, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd4, 32'h0000_0043), 8'hEF, 1, 8'hEF, 8'hEF, 0, 0);
    add(0, 1, flit(FLIT_BODY, 3'd4, 32'h0000_0044), 8'hFF, 1, 8'hEF, 8'hEF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hEF, 8'hEF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hEF, 8'hFF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hEF, 8'hFF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hEF, 8'hFF, 0, 1);
    add(0, 0, '0, 8'hFF, 0, 8'hEF, 8'hFF, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].on, vecs[i].push);
      check($sformatf("v%0d_alloc", i), 64'(is_allocatable), 64'(vecs[i].alloc));
      check($sformatf("v%0d_onoff", i), 64'(is_on_off), 64'(vecs[i].onoff));
      check($sformatf("v%0d_err", i), 64'(overflow_err), 64'(vecs[i].err));
      check($sformatf("v%0d_lvalid", i), 64'(link_valid), 64'(vecs[i].lv));
    end

    // round robin: preload VC7, VC5, VC1 while off; expect VC1, VC5, VC7
    step(1, 0, '0, 8'h00, 0);
    step(0, 1, flit(FLIT_HDR, 3'd7, 32'h0000_0070), 8'h00, 0);
    step(0, 1, flit(FLIT_HDR, 3'd5, 32'h0000_0050), 8'h00, 0);
    step(0, 1, flit(FLIT_HDR, 3'd1, 32'h0000_0010), 8'h00, 0);
    exp_q.push_back(flit(FLIT_HDR, 3'd1, 32'h0000_0010));
    exp_q.push_back(flit(FLIT_HDR, 3'd5, 32'h0000_0050));
    exp_q.push_back(flit(FLIT_HDR, 3'd7, 32'h0000_0070));
    repeat (3) step(0, 0, '0, 8'hFF, 0);
    step(0, 0, '0, 8'hFF, 0);
    check("rr1_idle", 64'(link_valid), 64'(0));
    // second round: VC7 and VC1 loaded, pointer back at 0
    step(0, 1, flit(FLIT_BODY, 3'd7, 32'h0000_0071), 8'h00, 0);
    step(0, 1, flit(FLIT_BODY, 3'd1, 32'h0000_0011), 8'h00, 0);
    exp_q.push_back(flit(FLIT_BODY, 3'd1, 32'h0000_0011));
    exp_q.push_back(flit(FLIT_BODY, 3'd7, 32'h0000_0071));
    repeat (2) step(0, 0, '0, 8'hFF, 0);
    step(0, 0, '0, 8'hFF, 0);
    check("rr2_idle", 64'(link_valid), 64'(0));
    check("rr_err", 64'(overflow_err), 64'(0));
    check("rr_alloc", 64'(is_allocatable), 64'(8'h5D));

    // reset while VC6 holds two flits and is owned
    step(1, 0, '0, 8'hBF, 0);
    step(0, 1, flit(FLIT_HDR,  3'd6, 32'h0000_0060), 8'hBF, 0);
    step(0, 1, flit(FLIT_BODY, 3'd6, 32'h0000_0061), 8'hBF, 0);
    check("vc6_owned", 64'(is_allocatable), 64'(8'hBF));
    step(1, 0, '0, 8'hFF, 0);
    check("rst_lvalid", 64'(link_valid), 64'(0));
    check("rst_alloc", 64'(is_allocatable), 64'(8'hFF));
    check("rst_onoff", 64'(is_on_off), 64'(8'hFF));
    check("rst_err", 64'(overflow_err), 64'(0));
    for (int k = 0; k < 4; k++) begin
      step(0, 0, '0, 8'hFF, 0);
      check($sformatf("post_rst_lvalid%0d", k), 64'(link_valid), 64'(0));
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
